// File: rtl/mem_xy_responder.sv
// mem_xy_responder: storage-side responder for the MemX/MemY interface.
// Two banks indexed from one common address, with self-clearing init and overflow tracking.
`default_nettype none

module mem_xy_responder #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_req,
  input  logic                  mem_we_x,
  input  logic                  mem_we_y,
  input  logic [2*ADDR_W-1:0]   common_address,
  input  logic [DATA_W-1:0]     MemWriteBus,
  input  logic                  MemOverflow,
  input  logic                  ovf_clear,
  output logic                  mem_ready,
  output logic [DATA_W-1:0]     memX_datain,
  output logic [DATA_W-1:0]     memY_datain,
  output logic                  mem_rvalid,
  output logic                  wr_ack,
  output logic                  ovf_sticky,
  output logic [2*ADDR_W-1:0]   ovf_addr,
  output logic [7:0]            wr_count
);

  localparam int unsigned c_depth = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_READ = 2'd2
  } state_t;

  state_t                state_q;
  logic [ADDR_W-1:0]     init_ptr_q;
  logic [2*ADDR_W-1:0]   rd_addr_q;
  logic                  mem_ready_q;
  logic                  mem_rvalid_q;
  logic                  wr_ack_q;
  logic                  ovf_sticky_q;
  logic [2*ADDR_W-1:0]   ovf_addr_q;
  logic [7:0]            wr_count_q;
  logic [7:0]            wr_count_d;
  logic [DATA_W-1:0]     rd_x_q;
  logic [DATA_W-1:0]     rd_y_q;
  logic [DATA_W-1:0]     bank_x_q [c_depth];
  logic [DATA_W-1:0]     bank_y_q [c_depth];

  logic                  w_init;
  logic                  w_is_write;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic                  w_x_we;
  logic                  w_y_we;
  logic [ADDR_W-1:0]     w_x_waddr;
  logic [ADDR_W-1:0]     w_y_waddr;
  logic [DATA_W-1:0]     w_wdata;

  // mem_ready_q is only high in IDLE, so it alone qualifies acceptance.
  assign w_init      = (state_q == ST_INIT);
  assign w_is_write  = mem_we_x | mem_we_y;
  assign w_wr_accept = mem_req & mem_ready_q & w_is_write;
  assign w_rd_accept = mem_req & mem_ready_q & ~w_is_write;

  assign w_x_we    = rst_n & (w_init | (w_wr_accept & mem_we_x));
  assign w_y_we    = rst_n & (w_init | (w_wr_accept & mem_we_y));
  assign w_x_waddr = w_init ? init_ptr_q : common_address[2*ADDR_W-1:ADDR_W];
  assign w_y_waddr = w_init ? init_ptr_q : common_address[ADDR_W-1:0];
  assign w_wdata   = w_init ? '0 : MemWriteBus;

  assign wr_count_d = (wr_count_q == 8'hFF) ? wr_count_q : wr_count_q + 8'd1;

  always_ff @(posedge clk) begin
    if (w_x_we) bank_x_q[w_x_waddr] <= w_wdata;
    if (w_y_we) bank_y_q[w_y_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_ptr_q   <= '0;
      rd_addr_q    <= '0;
      mem_ready_q  <= 1'b0;
      mem_rvalid_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      ovf_sticky_q <= 1'b0;
      ovf_addr_q   <= '0;
      wr_count_q   <= '0;
      rd_x_q       <= '0;
      rd_y_q       <= '0;
    end else begin
      mem_rvalid_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      // A same-cycle overflow below overrides this clear.
      if (ovf_clear) ovf_sticky_q <= 1'b0;
      case (state_q)
        ST_INIT: begin
          init_ptr_q <= init_ptr_q + ADDR_W'(1);
          if (init_ptr_q == '1) begin
            state_q     <= ST_IDLE;
            mem_ready_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_wr_accept) begin
            wr_ack_q   <= 1'b1;
            wr_count_q <= wr_count_d;
            if (MemOverflow) begin
              ovf_sticky_q <= 1'b1;
              if (!ovf_sticky_q || ovf_clear) ovf_addr_q <= common_address;
            end
          end else if (w_rd_accept) begin
            rd_addr_q   <= common_address;
            state_q     <= ST_READ;
            mem_ready_q <= 1'b0;
          end
        end
        ST_READ: begin
          rd_x_q       <= bank_x_q[rd_addr_q[2*ADDR_W-1:ADDR_W]];
          rd_y_q       <= bank_y_q[rd_addr_q[ADDR_W-1:0]];
          mem_rvalid_q <= 1'b1;
          state_q      <= ST_IDLE;
          mem_ready_q  <= 1'b1;
        end
        default: begin
          state_q     <= ST_INIT;
          init_ptr_q  <= '0;
          mem_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_ready   = mem_ready_q;
  assign memX_datain = rd_x_q;
  assign memY_datain = rd_y_q;
  assign mem_rvalid  = mem_rvalid_q;
  assign wr_ack      = wr_ack_q;
  assign ovf_sticky  = ovf_sticky_q;
  assign ovf_addr    = ovf_addr_q;
  assign wr_count    = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_xy_responder.sv
// tb_mem_xy_responder: table-driven and randomized checks against a bank-array reference model.
`default_nettype none

module tb_mem_xy_responder;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic        mem_we_x;
  logic        mem_we_y;
  logic [7:0]  common_address;
  logic [63:0] MemWriteBus;
  logic        MemOverflow;
  logic        ovf_clear;
  logic        mem_ready;
  logic [63:0] memX_datain;
  logic [63:0] memY_datain;
  logic        mem_rvalid;
  logic        wr_ack;
  logic        ovf_sticky;
  logic [7:0]  ovf_addr;
  logic [7:0]  wr_count;

  mem_xy_responder #(.DATA_W(64), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_we_x(mem_we_x), .mem_we_y(mem_we_y),
    .common_address(common_address), .MemWriteBus(MemWriteBus), .MemOverflow(MemOverflow),
    .ovf_clear(ovf_clear), .mem_ready(mem_ready), .memX_datain(memX_datain),
    .memY_datain(memY_datain), .mem_rvalid(mem_rvalid), .wr_ack(wr_ack),
    .ovf_sticky(ovf_sticky), .ovf_addr(ovf_addr), .wr_count(wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain arrays plus the tracked status values.
  logic [63:0] mx [16];
  logic [63:0] my [16];
  logic [63:0] m_last_x, m_last_y;
  logic        m_sticky;
  logic [7:0]  m_oaddr;
  int          m_count;

  typedef struct {
    int          op;      // 0 write, 1 read, 2 clear
    logic [7:0]  addr;
    logic        wx;
    logic        wy;
    logic [63:0] data;
    logic        ovf;
    logic        clr;
    logic [63:0] ex;
    logic [63:0] ey;
    logic        es;
    logic [7:0]  ea;
    logic [7:0]  ec;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      mx[i] = '0;
      my[i] = '0;
    end
    m_last_x = '0;
    m_last_y = '0;
    m_sticky = 1'b0;
    m_oaddr  = '0;
    m_count  = 0;
  endtask

  task automatic idle_inputs();
    mem_req = 1'b0; mem_we_x = 1'b0; mem_we_y = 1'b0;
    MemOverflow = 1'b0; ovf_clear = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", mem_ready, 0);
    chk("rst_rvalid", mem_rvalid, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_oaddr", ovf_addr, 0);
    chk("rst_count", wr_count, 0);
    chk("rst_dx", memX_datain, 0);
    chk("rst_dy", memY_datain, 0);
  endtask

  // Entered at the negedge where rst_n was just released; holds a write request throughout INIT.
  task automatic wait_init();
    int cnt = 0;
    bit ack_seen = 0;
    mem_req = 1'b1; mem_we_x = 1'b1; mem_we_y = 1'b1;
    common_address = 8'h55; MemWriteBus = 64'hDEAD_BEEF_0BAD_F00D; MemOverflow = 1'b1;
    while (cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (wr_ack || mem_rvalid) ack_seen = 1;
      if (mem_ready) break;
    end
    idle_inputs();
    if (!mem_ready) $display("FAIL init_timeout actual=not_ready expected=ready");
    chk("init_not_ready_cycles", cnt, 16);
    chk("init_no_ack", ack_seen, 0);
    chk("init_sticky", ovf_sticky, 0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic wx, input logic wy,
                          input logic [63:0] d, input logic ovf, input logic clr);
    mem_req = 1'b1; mem_we_x = wx; mem_we_y = wy; common_address = a;
    MemWriteBus = d; MemOverflow = ovf; ovf_clear = clr;
    @(negedge clk);
    idle_inputs();
    if (wx) mx[a[7:4]] = d;
    if (wy) my[a[3:0]] = d;
    if (ovf) begin
      if (!m_sticky || clr) m_oaddr = a;
      m_sticky = 1'b1;
    end else if (clr) begin
      m_sticky = 1'b0;
    end
    if (m_count < 255) m_count++;
    chk("wr_ack", wr_ack, 1);
    chk("wr_ready", mem_ready, 1);
    chk("wr_sticky", ovf_sticky, m_sticky);
    chk("wr_oaddr", ovf_addr, m_oaddr);
    chk("wr_count", wr_count, m_count);
    chk("wr_hold_x", memX_datain, m_last_x);
  endtask

  task automatic do_read(input logic [7:0] a, input bit drop);
    mem_req = 1'b1; mem_we_x = 1'b0; mem_we_y = 1'b0; common_address = a;
    MemOverflow = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("rd_busy_ready", mem_ready, 0);
    chk("rd_early_rvalid", mem_rvalid, 0);
    if (drop) begin
      mem_we_x = 1'b1; mem_we_y = 1'b1; MemOverflow = 1'b1;
      MemWriteBus = {$urandom, $urandom};
    end else begin
      idle_inputs();
    end
    @(negedge clk);
    idle_inputs();
    m_last_x = mx[a[7:4]];
    m_last_y = my[a[3:0]];
    chk("rd_rvalid", mem_rvalid, 1);
    chk("rd_ready", mem_ready, 1);
    chk("rd_x", memX_datain, m_last_x);
    chk("rd_y", memY_datain, m_last_y);
    @(negedge clk);
    chk("rd_rvalid_pulse", mem_rvalid, 0);
    chk("rd_no_ack", wr_ack, 0);
    chk("rd_sticky", ovf_sticky, m_sticky);
    chk("rd_count", wr_count, m_count);
  endtask

  task automatic do_clear();
    ovf_clear = 1'b1;
    @(negedge clk);
    ovf_clear = 1'b0;
    m_sticky = 1'b0;
    chk("clr_sticky", ovf_sticky, 0);
    chk("clr_oaddr", ovf_addr, m_oaddr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{0, 8'h3A, 1, 0, 64'h1122334455667788, 0, 0, 0, 0, 0, 8'h00, 8'd1};
    tbl[1]  = '{0, 8'h05, 0, 1, 64'h000000000000AAAA, 0, 0, 0, 0, 0, 8'h00, 8'd2};
    tbl[2]  = '{1, 8'h35, 0, 0, 0, 0, 0, 64'h1122334455667788, 64'hAAAA, 0, 8'h00, 8'd2};
    tbl[3]  = '{0, 8'h77, 1, 1, 64'hF0, 1, 0, 0, 0, 1, 8'h77, 8'd3};
    tbl[4]  = '{0, 8'h12, 1, 1, 64'h55, 1, 0, 0, 0, 1, 8'h77, 8'd4};
    tbl[5]  = '{2, 8'h00, 0, 0, 0, 0, 1, 0, 0, 0, 8'h77, 8'd4};
    tbl[6]  = '{0, 8'h12, 1, 1, 64'h66, 1, 0, 0, 0, 1, 8'h12, 8'd5};
    tbl[7]  = '{0, 8'h40, 1, 0, 64'h99, 1, 1, 0, 0, 1, 8'h40, 8'd6};
    tbl[8]  = '{1, 8'h77, 0, 0, 0, 0, 0, 64'hF0, 64'hF0, 1, 8'h40, 8'd6};
    tbl[9]  = '{1, 8'h42, 0, 0, 0, 0, 0, 64'h99, 64'h66, 1, 8'h40, 8'd6};
    tbl[10] = '{1, 8'h3A, 0, 0, 0, 0, 0, 64'h1122334455667788, 64'h0, 1, 8'h40, 8'd6};

    rst_n = 1'b0; common_address = '0; MemWriteBus = '0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    wait_init();
    for (int i = 0; i < 16; i++) do_read(8'(i * 17), 0);

    for (int i = 0; i < 11; i++) begin
      case (tbl[i].op)
        0: do_write(tbl[i].addr, tbl[i].wx, tbl[i].wy, tbl[i].data, tbl[i].ovf, tbl[i].clr);
        1: do_read(tbl[i].addr, 0);
        default: do_clear();
      endcase
      if (tbl[i].op == 1) begin
        chk($sformatf("tbl%0d_x", i), memX_datain, tbl[i].ex);
        chk($sformatf("tbl%0d_y", i), memY_datain, tbl[i].ey);
      end
      chk($sformatf("tbl%0d_sticky", i), ovf_sticky, tbl[i].es);
      chk($sformatf("tbl%0d_oaddr", i), ovf_addr, tbl[i].ea);
      chk($sformatf("tbl%0d_count", i), wr_count, tbl[i].ec);
    end

    // Write presented during the READ cycle must vanish.
    do_read(8'h77, 1);
    do_read(8'h77, 0);
    chk("drop_x_unchanged", memX_datain, 64'hF0);
    chk("drop_y_unchanged", memY_datain, 64'hF0);
    chk("drop_count", wr_count, 8'd6);

    for (int n = 0; n < 150; n++) begin
      int unsigned r;
      int unsigned k;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        k = $urandom_range(1, 3);
        do_write(8'($urandom), k[0], k[1], {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      end else if (r < 8) begin
        do_read(8'($urandom), bit'($urandom_range(0, 1)));
      end else if (r == 8) begin
        do_clear();
      end else begin
        @(negedge clk);
        chk("idle_no_ack", wr_ack, 0);
      end
    end

    for (int n = 0; n < 300; n++)
      do_write(8'($urandom), 1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0, 1'b0);
    chk("sat_count", wr_count, 8'd255);
    @(negedge clk);
    chk("sat_hold", wr_count, 8'd255);

    // Reset again partway through INIT.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_vals();
    model_reset();
    rst_n = 1'b1;
    wait_init();
    chk("reinit_count", wr_count, 8'd0);
    chk("reinit_sticky", ovf_sticky, 0);
    chk("reinit_oaddr", ovf_addr, 8'h00);
    for (int i = 0; i < 16; i++) do_read(8'(i * 17), 0);
    do_read(8'hF0, 0);
    chk("reinit_x", memX_datain, 64'h0);
    chk("reinit_y", memY_datain, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
